// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, skid-stage state enum and lane-bus helpers.
package cpu_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic int unsigned bus_w(input int unsigned w, input int unsigned lanes);
        return w * lanes;
    endfunction

    function automatic logic [1:0] occ_of(input state_t st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// One lane of a pipeline register: {pc, instr, valid} with load, clear and NOP masking.
module pipe_lane_reg #(
    parameter int unsigned          PC_W    = 32,
    parameter int unsigned          INSTR_W = 32,
    parameter logic [INSTR_W-1:0]   NOP     = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               clear,
    input  logic [PC_W-1:0]    d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic               d_vld,
    output logic [PC_W-1:0]    q_pc,
    output logic [INSTR_W-1:0] q_instr,
    output logic               q_vld
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_pc    <= '0;
            q_instr <= NOP;
            q_vld   <= 1'b0;
        end else if (clear) begin
            q_instr <= NOP;
            q_vld   <= 1'b0;
        end else if (load) begin
            q_pc    <= d_pc;
            q_instr <= d_vld ? d_instr : NOP;
            q_vld   <= d_vld;
        end
    end

endmodule

// File: rtl/pipe_ifid_skid.sv
// IF/ID pipeline stage with a 2-entry skid buffer (head H, skid S), flush and per-lane bubbles.
module pipe_ifid_skid
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned        PC_W    = 32,
    parameter int unsigned        INSTR_W = 32,
    parameter int unsigned        LANES   = 1,
    parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [bus_w(PC_W, LANES)-1:0]     in_pc,
    input  logic [bus_w(INSTR_W, LANES)-1:0]  in_instr,
    input  logic [LANES-1:0]                  in_lane_vld,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [bus_w(PC_W, LANES)-1:0]     out_pc,
    output logic [bus_w(INSTR_W, LANES)-1:0]  out_instr,
    output logic [LANES-1:0]                  out_lane_vld,
    output logic [1:0]                        occupancy
);

    state_t state_q, state_d;
    logic   in_ready_q;
    logic   acc, pop;
    logic   h_load, s_load, h_from_s;

    logic [bus_w(PC_W, LANES)-1:0]    h_pc, s_pc;
    logic [bus_w(INSTR_W, LANES)-1:0] h_instr, s_instr;
    logic [LANES-1:0]                 h_vld, s_vld;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign acc       = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign h_from_s  = (state_q == ST_TWO);
    assign occupancy = occ_of(state_q);
    assign out_pc    = h_pc;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        h_load  = 1'b0;
        s_load  = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d = ST_ONE;
                    h_load  = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    h_load = 1'b1;
                end else if (acc) begin
                    state_d = ST_TWO;
                    s_load  = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    h_load  = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            h_load  = 1'b0;
            s_load  = 1'b0;
        end
    end

    // in_ready comes from next state so it is a flop output with no path from in_valid or out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pipe_lane_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP(NOP)) u_head (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (h_load),
            .clear   (flush),
            .d_pc    (h_from_s ? s_pc[i*PC_W +: PC_W]         : in_pc[i*PC_W +: PC_W]),
            .d_instr (h_from_s ? s_instr[i*INSTR_W +: INSTR_W] : in_instr[i*INSTR_W +: INSTR_W]),
            .d_vld   (h_from_s ? s_vld[i]                      : in_lane_vld[i]),
            .q_pc    (h_pc[i*PC_W +: PC_W]),
            .q_instr (h_instr[i*INSTR_W +: INSTR_W]),
            .q_vld   (h_vld[i])
        );

        pipe_lane_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP(NOP)) u_skid (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (s_load),
            .clear   (flush),
            .d_pc    (in_pc[i*PC_W +: PC_W]),
            .d_instr (in_instr[i*INSTR_W +: INSTR_W]),
            .d_vld   (in_lane_vld[i]),
            .q_pc    (s_pc[i*PC_W +: PC_W]),
            .q_instr (s_instr[i*INSTR_W +: INSTR_W]),
            .q_vld   (s_vld[i])
        );

        // H keeps stale data after draining to EMPTY, so lanes are gated by out_valid.
        assign out_lane_vld[i]                   = h_vld[i] & out_valid;
        assign out_instr[i*INSTR_W +: INSTR_W]   = out_lane_vld[i] ? h_instr[i*INSTR_W +: INSTR_W] : NOP;
    end

endmodule

// File: tb/tb_pipe_ifid_skid.sv
// Self-checking bench for pipe_ifid_skid (LANES=2): scoreboard on every beat plus directed checks.
module tb_pipe_ifid_skid;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int LANES   = 2;

    logic                     clk;
    logic                     reset_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*PC_W-1:0]    in_pc;
    logic [LANES*INSTR_W-1:0] in_instr;
    logic [LANES-1:0]         in_lane_vld;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*PC_W-1:0]    out_pc;
    logic [LANES*INSTR_W-1:0] out_instr;
    logic [LANES-1:0]         out_lane_vld;
    logic [1:0]               occupancy;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] instr;
        logic [1:0]  vld;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;

    pipe_ifid_skid #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LANES(LANES)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_lane_vld  (in_lane_vld),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_lane_vld (out_lane_vld),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] lv,
                         input logic [31:0] i0, input logic [31:0] i1);
        in_valid    = v;
        in_pc       = {pc + 32'd4, pc};
        in_lane_vld = lv;
        in_instr    = {i1, i0};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs and outputs are stable at the falling edge; transfers happen on the next rise.
    always @(negedge clk) begin
        if (!reset_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    check("sb_pc", out_pc, e.pc);
                    check("sb_instr", out_instr, e.instr);
                    check("sb_lane_vld", 64'(out_lane_vld), 64'(e.vld));
                end
            end
            if (in_valid && in_ready) begin
                beat_t e;
                e.pc    = in_pc;
                e.vld   = in_lane_vld;
                e.instr[31:0]  = in_lane_vld[0] ? in_instr[31:0]  : 32'h0;
                e.instr[63:32] = in_lane_vld[1] ? in_instr[63:32] : 32'h0;
                sb.push_back(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 2'b00, 32'h1000, 32'h2000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", out_instr, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_lane_vld", 64'(out_lane_vld), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;

        // Streaming: 8 beats, one per cycle, lane masks cycling through 00/01/10/11.
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_pc", 64'(out_pc[31:0]), 64'(32'h100 + 32'(8 * i)));
            check("stream_occ", 64'(occupancy), 64'd1);
            if (i < 7)
                drive(1'b1, 32'h100 + 32'(8 * (i + 1)), 2'(i + 1),
                      32'h1000 + 32'(i + 1), 32'h2000 + 32'(i + 1));
            else
                in_valid = 1'b0;
        end
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_occ", 64'(occupancy), 64'd0);

        // Stall: decoder holds off while three beats arrive.
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 2'b11, 32'hA0, 32'hA1);
        tick();
        check("stall_occ1", 64'(occupancy), 64'd1);
        check("stall_rdy1", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h204, 2'b11, 32'hB0, 32'hB1);
        tick();
        check("stall_occ2", 64'(occupancy), 64'd2);
        check("stall_rdy2", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h208, 2'b11, 32'hC0, 32'hC1);
        tick();
        check("stall_occ3", 64'(occupancy), 64'd2);
        check("stall_rdy3", 64'(in_ready), 64'd0);
        check("stall_hold_pc", 64'(out_pc[31:0]), 64'h200);
        check("stall_hold_instr", out_instr, {32'hA1, 32'hA0});
        out_ready = 1'b1;
        tick();
        check("release_pc1", 64'(out_pc[31:0]), 64'h204);
        check("release_rdy", 64'(in_ready), 64'd1);
        check("release_occ", 64'(occupancy), 64'd1);
        tick();
        check("release_pc2", 64'(out_pc[31:0]), 64'h208);
        in_valid = 1'b0;
        tick();
        check("release_empty", 64'(occupancy), 64'd0);

        // Flush while EMPTY is a no-op.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty_occ", 64'(occupancy), 64'd0);
        check("flush_empty_rdy", 64'(in_ready), 64'd1);

        // Flush in TWO with an incoming beat.
        out_ready = 1'b0;
        drive(1'b1, 32'h280, 2'b11, 32'hD0, 32'hD1);
        tick();
        drive(1'b1, 32'h284, 2'b11, 32'hE0, 32'hE1);
        tick();
        check("pre_flush_occ", 64'(occupancy), 64'd2);
        drive(1'b1, 32'h300, 2'b11, 32'hF0, 32'hF1);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush2_valid", 64'(out_valid), 64'd0);
        check("flush2_occ", 64'(occupancy), 64'd0);
        check("flush2_rdy", 64'(in_ready), 64'd1);
        check("flush2_instr", out_instr, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("flush2_no_replay", 64'(out_valid), 64'd0);
        end

        // Flush in ONE drops the beat offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 32'h380, 2'b11, 32'h11, 32'h12);
        tick();
        drive(1'b1, 32'h390, 2'b11, 32'h13, 32'h14);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush1_occ", 64'(occupancy), 64'd0);
        check("flush1_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick();
        check("flush1_dropped", 64'(out_valid), 64'd0);

        // Lane mask: lane0 becomes a bubble.
        drive(1'b1, 32'h400, 2'b10, 32'h1234, 32'h8C01);
        tick();
        in_valid = 1'b0;
        check("mask_lane0", 64'(out_instr[31:0]), 64'd0);
        check("mask_lane1", 64'(out_instr[63:32]), 64'h8C01);
        check("mask_lane_vld", 64'(out_lane_vld), 64'(2'b10));
        tick();

        // All-bubble beat is still carried.
        drive(1'b1, 32'h500, 2'b00, 32'h55, 32'h66);
        tick();
        in_valid = 1'b0;
        check("bubble_valid", 64'(out_valid), 64'd1);
        check("bubble_lane_vld", 64'(out_lane_vld), 64'd0);
        check("bubble_instr", out_instr, 64'd0);
        tick();

        // Asynchronous reset in TWO takes effect before the next edge.
        out_ready = 1'b0;
        drive(1'b1, 32'h600, 2'b11, 32'h61, 32'h62);
        tick();
        drive(1'b1, 32'h604, 2'b11, 32'h63, 32'h64);
        tick();
        in_valid = 1'b0;
        check("pre_reset_occ", 64'(occupancy), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_valid", 64'(out_valid), 64'd0);
        check("areset_occ", 64'(occupancy), 64'd0);
        check("areset_rdy", 64'(in_ready), 64'd1);
        check("areset_instr", out_instr, 64'd0);
        check("areset_pc", out_pc, 64'd0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_reset_valid", 64'(out_valid), 64'd0);
        tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
